// File: rtl/mips_loader_pkg.sv
// Shared state encoding, byte-format constants and sizing helper for the MIPS program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_loader_pkg;

  localparam int HDR_BYTES   = 2;
  localparam int WORD_BYTES  = 4;
  localparam int INSTR_WIDTH = 32;

  // Word counts are carried at 17 bits so a full 16-bit header can be compared
  // against DEPTH (up to 65536) without wrapping.
  localparam int CNT_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CLEAR,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Number of instruction-memory words for a given word-address width.
  function automatic logic [CNT_W-1:0] depth_of(input int addr_width);
    return CNT_W'(1) << addr_width;
  endfunction

endpackage

// File: rtl/mips_program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// Latency: n/a (wires only).
// Backpressure: in_ready from the loader; the write side has none, memory accepts every strobe.
interface mips_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                                   in_valid;
  logic [7:0]                             in_data;
  logic                                   in_ready;
  logic                                   imem_we;
  logic [ADDR_WIDTH-1:0]                  imem_addr;
  logic [mips_loader_pkg::INSTR_WIDTH-1:0] imem_wdata;

  // Stream producer / memory side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Packs accepted stream bytes big-endian into 32-bit words; flush discards a partial word.
// Latency: word_vld/word_dat are combinational with the 4th accepted byte.
// Backpressure: none; the parent only asserts accept on a real handshake.
module loader_word_assembler
  import mips_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   accept,
  input  logic                   flush,
  input  logic [7:0]             byte_dat,
  output logic                   word_vld,
  output logic [INSTR_WIDTH-1:0] word_dat
);

  localparam int IDX_W   = $clog2(WORD_BYTES);
  localparam int SHIFT_W = (WORD_BYTES - 1) * 8;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // Byte index advance, shift-in of earlier bytes, and completion on the last byte.
  always_comb begin
    idx_d    = idx_q;
    shift_d  = shift_q;
    word_vld = accept && (idx_q == IDX_W'(WORD_BYTES - 1));
    word_dat = {shift_q, byte_dat};
    if (flush) begin
      idx_d    = '0;
      shift_d  = '0;
      word_vld = 1'b0;
    end else if (accept) begin
      idx_d   = idx_q + IDX_W'(1);
      shift_d = {shift_q[SHIFT_W-9:0], byte_dat};
    end
  end

  // Assembly state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/mips_program_loader.sv
// Loads a length-prefixed byte image into instruction memory, zero-fills the rest, then releases cpu_reset.
// Latency: write strobe one cycle after the 4th byte handshake; load_done 1 cycle, cpu_reset low 2 cycles after the last write.
// Backpressure: in_ready high only while receiving header or data; CLEAR, DONE and ERROR refuse bytes.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  mips_program_loader_if.slave bus,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_error
);

  localparam logic [CNT_W-1:0] DEPTH_C = depth_of(ADDR_WIDTH);

  state_e                    state_q, state_d;
  logic [(HDR_BYTES-1)*8-1:0] hdr_hi_q, hdr_hi_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          word_idx_q, word_idx_d;
  logic [CNT_W-1:0]          clr_idx_q, clr_idx_d;

  logic                      imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]     imem_addr_q, imem_addr_d;
  logic [INSTR_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;
  logic                      cpu_reset_q, cpu_reset_d;
  logic                      load_done_q, load_done_d;
  logic                      load_error_q, load_error_d;

  logic                      in_ready;
  logic                      hs;
  logic                      word_vld;
  logic [INSTR_WIDTH-1:0]    word_dat;
  logic [CNT_W-1:0]          hdr_cnt;
  logic [CNT_W-1:0]          word_idx_nxt;

  // Only the receiving states take bytes; a byte coinciding with start is dropped.
  assign in_ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) || (state_q == ST_DATA);
  assign hs       = bus.in_valid && in_ready && !start;
  assign hdr_cnt  = CNT_W'({hdr_hi_q, bus.in_data});
  assign word_idx_nxt = word_idx_q + CNT_W'(1);

  loader_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .accept   (hs && (state_q == ST_DATA)),
    .flush    (start),
    .byte_dat (bus.in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d      = state_q;
    hdr_hi_d     = hdr_hi_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    clr_idx_d    = clr_idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      ST_IDLE: state_d = ST_HDR_HI;
      ST_HDR_HI: begin
        if (hs) begin
          hdr_hi_d = bus.in_data;
          state_d  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (hs) begin
          count_d    = hdr_cnt;
          word_idx_d = '0;
          clr_idx_d  = hdr_cnt;
          if (hdr_cnt > DEPTH_C) begin
            state_d = ST_ERROR;
          end else if (hdr_cnt == '0) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_vld) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
          imem_wdata_d = word_dat;
          word_idx_d   = word_idx_nxt;
          if (word_idx_nxt == count_q) begin
            clr_idx_d = count_q;
            state_d   = (count_q == DEPTH_C) ? ST_DONE : ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = clr_idx_q[ADDR_WIDTH-1:0];
        imem_wdata_d = '0;
        clr_idx_d    = clr_idx_q + CNT_W'(1);
        if (clr_idx_q == DEPTH_C - CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  ;
      ST_ERROR: ;
      default:  state_d = ST_IDLE;
    endcase

    // start aborts whatever is in flight, including a write that would have issued now.
    if (start) begin
      state_d    = ST_HDR_HI;
      word_idx_d = '0;
      clr_idx_d  = '0;
      imem_we_d  = 1'b0;
    end

    // load_done follows DONE by one cycle and cpu_reset releases one cycle after that.
    load_done_d  = (state_q == ST_DONE) && !start;
    cpu_reset_d  = !((state_q == ST_DONE) && load_done_q && !start);
    load_error_d = (state_d == ST_ERROR);
  end

  // FSM, header/counter state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hdr_hi_q     <= '0;
      count_q      <= '0;
      word_idx_q   <= '0;
      clr_idx_q    <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_hi_q     <= hdr_hi_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      clr_idx_q    <= clr_idx_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;

endmodule

// File: doc/mips_program_loader.md
# mips_program_loader

Byte-stream program loader that sits directly upstream of `mips_single_cycle`. It receives a length-prefixed byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes those words into the processor's instruction memory and zero-fills the remaining locations. It holds the processor in reset until the image is complete, replacing hierarchical memory pokes with a synthesizable load path.

## Interface
- `ADDR_WIDTH`, 8: instruction-memory word-address width; `DEPTH = 2**ADDR_WIDTH` words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; aborts any load and restarts header reception.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a byte transfers on an edge where `in_valid && in_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  word to write.
- `cpu_reset`  out  1  reset to `mips_single_cycle`.
- `load_done`  out  1  image loaded; the processor is running.
- `load_error`  out  1  header word count exceeds `DEPTH`.

## Operation
- The stream format is a 16-bit word count N, sent MSB byte first, followed by 4·N instruction bytes. Each word is sent big-endian, so the first byte becomes `[31:24]`.
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, CLEAR, DONE, ERROR.
- IDLE always moves to HDR_HI on the next edge.
- HDR_HI captures the high count byte on a handshake and moves to HDR_LO.
- HDR_LO captures the low count byte on a handshake, then branches on N:
  - N > DEPTH: go to ERROR.
  - N == 0: go to CLEAR.
  - Otherwise: go to DATA.
- DATA:
  - A 2-bit byte index assembles each word.
  - On the 4th byte handshake, the block registers a write of the assembled word at the current word index, then increments the word index.
  - After word N−1 is written, the FSM goes to CLEAR if N < DEPTH, or to DONE if N == DEPTH.
- CLEAR writes `0x00000000` to addresses N … DEPTH−1, one address per cycle. After address DEPTH−1 is written, the FSM goes to DONE.
- DONE asserts `load_done`, deasserts `cpu_reset`, and ignores the stream.
- ERROR asserts `load_error`, keeps `cpu_reset` high, and waits for `start`.
- `in_ready` is high exactly in HDR_HI, HDR_LO and DATA.
- `start` in any state:
  - The FSM goes to HDR_HI on the next edge.
  - The byte index and word index clear, and `load_done` and `load_error` clear.
  - `cpu_reset` rises.
  - A partially assembled word is discarded, and any handshake in that same cycle is ignored.
- The header is compared against DEPTH at 17-bit width, so N = 65535 with ADDR_WIDTH = 16 is legal and never wraps.

## Timing
- Reset values:
  - State: IDLE.
  - `in_ready` = 0.
  - `imem_we` = 0; `imem_addr` = 0; `imem_wdata` = 0.
  - `cpu_reset` = 1.
  - `load_done` = 0; `load_error` = 0.
- `in_ready` first rises in the 2nd cycle after reset deassertion.
- All outputs are registered except `in_ready`, which decodes the state.
- Write latency:
  - A 4th-byte handshake on edge k produces `imem_we` = 1 in the cycle after k, with matching address and data.
  - In CLEAR, one write occurs per cycle with no gaps.
- Completion timing: if the final write pulse is in cycle t, then `load_done` = 1 from cycle t+1 and `cpu_reset` = 0 from cycle t+2.
- Gaps in `in_valid` stall assembly without losing bytes. `in_data` is sampled only on a handshake.
- Reset asserted mid-load drops all outputs to their reset values immediately. No partial write is emitted.

## Structure
- `mips_loader_pkg`: state enum, `HDR_BYTES` = 2, `WORD_BYTES` = 4, `INSTR_WIDTH` = 32.
- Sub-module `loader_word_assembler`:
  - Contains the byte index, the shift register and the word-complete pulse.
  - Takes the accept strobe and a flush signal.
  - Is instantiated once.
- The top level holds the FSM, the header register, the word counter, the clear counter and the output registers.

## Test plan
- Full load of 10 words: header `00 0A`, then `0x20090005, 0x200A000A, 0x012A4020, 0x012A4022, 0x012A4024, 0x012A4025, 0xAC0A0000, 0x8C0B0000, 0x11690002, 0x08000000`, with `in_valid` held high.
  - Writes at addresses 0–9 carry exactly these words.
  - 246 zero writes follow at addresses 10–255, with 256 `imem_we` pulses in total.
  - `load_done` rises, then `cpu_reset` falls one cycle later.
  - Connected to `mips_single_cycle`, the processor ends with `$t1` = 5, `$t2` = 10 and `$t3` = 10.
- Random `in_valid` gaps (≈50%) on the same image: the writes are identical to the full-load case and `in_ready` never drops inside DATA.
- Header `00 00`: 256 zero writes, then `load_done` = 1 and `cpu_reset` = 0 two cycles after the last write.
- Header `01 2C` (300) with ADDR_WIDTH = 8:
  - `load_error` = 1, `in_ready` = 0, `cpu_reset` stays 1 and no writes occur.
  - A subsequent `start` followed by a valid image loads normally.
- `start` after 2.5 words of a 10-word load, followed by a fresh 3-word image: only the fresh words are written at addresses 0–2 and no half-word write appears.
- `reset` asserted mid-DATA: in that same cycle `imem_we` = 0, `cpu_reset` = 1 and `in_ready` = 0. After release, a full reload succeeds.
